mmio_ctrl: RTL
==============

# mmio_ctrl

Memory-mapped I/O controller sitting directly downstream of the processor's data-memory port (write-back stage address/data/write-enable). It decodes accesses to the 0xFFF0–0xFFFF window, owns the HEX, LEDR and LEDG output registers, synchronizes and debounces KEY and SW, latches sticky key-press events, and provides a free-running millisecond counter. Read data is combinational so the processor's load path timing is unchanged.

## Interface
Parameters:
- DBITS, 16, data/address width
- DEB_CYCLES, 500000, debounce sample period in clk cycles (10 ms at 50 MHz); must be ≥2
- TICK_CYCLES, 50000, clk cycles per millisecond tick; must be ≥2

Ports:
- clk  in  1  system clock; every register updates on its rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- addr  in  DBITS  data address from the processor
- wdata  in  DBITS  store data
- we  in  1  store strobe; honored only when io_sel=1
- rdata  out  DBITS  load data, combinational from addr and internal registers
- io_sel  out  1  combinational; 1 when addr[15:4]==12'hFFF
- key_n  in  4  raw pushbuttons, active-low, asynchronous
- sw  in  10  raw slide switches, asynchronous
- hex_out  out  16  value for the four seven-segment digits
- ledr  out  10  red LEDs
- ledg  out  8  green LEDs

## Operation
- Register map (word addresses; addr[0] ignored):
  - FFF0 KEY (R): {12'b0, key_db}; key_db is debounced key_n, 1=released. Writes ignored.
  - FFF2 SW (R): {6'b0, sw_db}. Writes ignored.
  - FFF4 KSTAT (R/W1C): {12'b0, kstat}; bit i set on a debounced 1→0 transition of key_db[i]; writing 1 clears the bit, 0 leaves it.
  - FFF6 MSCNT (R/W): 16-bit millisecond counter; write loads wdata.
  - FFF8 HEX (R/W), FFFA LEDR (R/W, bits [9:0]), FFFC LEDG (R/W, bits [7:0]); reads return zero-extended contents.
  - FFFE: reads 16'h0000, writes ignored.
- io_sel=0: rdata=16'hDEAD, writes ignored.
- Input path: key_n and sw each pass a 2-flop synchronizer (reset: key 4'hF, sw 0).
- Debounce: shared prescaler counts 0..DEB_CYCLES-1, pulse deb_tick on terminal count. On deb_tick: samp <= sync; per bit, stable <= sync if samp==sync, else hold. key_db/sw_db are the stable registers.
- Key events: kstat[i] sets when key_db[i] goes 1→0 in a cycle. Set and W1C on same bit same cycle → bit stays set.
- Timer: prescaler 0..TICK_CYCLES-1; ms_tick on terminal count increments MSCNT, wrapping FFFF→0000. Write to MSCNT in a tick cycle → written value wins, no increment; prescaler not reset by the write.

## Timing
- Reset (rst_n=0 at an edge): hex_out, ledr, ledg, MSCNT, kstat, both prescalers =0; key sync/samp/key_db =4'hF; sw sync/samp/sw_db =0. Asserting rst_n mid-operation discards pending debounce and prescaler state identically.
- Stores: register updates at the clk edge where io_sel&&we; output pins reflect the new value the following cycle (1-cycle latency). No stall, no handshake; every access completes in one cycle.
- Loads: rdata valid in the same cycle as addr; a store and load to the same register in one cycle returns the old value.
- Input latency: a raw change stable long enough appears in key_db/sw_db after 2 sync cycles plus 1–2 deb_ticks (≤2·DEB_CYCLES+3 cycles); a glitch shorter than one DEB_CYCLES period that does not straddle two consecutive ticks is rejected.
- kstat bit visible on read the cycle after key_db falls.
- MSCNT first increments TICK_CYCLES cycles after reset release.

## Test plan
Use DEB_CYCLES=4, TICK_CYCLES=5.
- Reset: hold rst_n=0 3 cycles, key_n=4'h0 → after release hex_out=0, ledr=0, ledg=0; read FFF0=000F, FFF4=0000, FFF6=0000.
- Output writes: store FFF8←BEEF, FFFA←03FF, FFFC←FFA5, FFF2←1234 → hex_out=BEEF, ledr=3FF, ledg=A5 next cycle; readback FFFA=03FF, FFFC=00A5; FFF2 still reads switch value; store to 0x0100 (io_sel=0) changes nothing, rdata=DEAD.
- Debounce: drive key_n[1]=0 steadily → FFF0 reads 000D within 11 cycles and FFF4 reads 0002; 2-cycle pulse on key_n[2] between ticks → FFF0 stays 000D, kstat[2]=0.
- W1C collision: with kstat=0002, write FFF4←0002 in the same cycle key_db[3] falls → FFF4 reads 0008; W1C coinciding with a new fall on bit 1 → bit 1 stays 1.
- Timer: after reset, MSCNT=1 at cycle 5, 2 at cycle 10; write FFF6←FFFF, then next tick → 0000; write 1234 in a tick cycle → reads 1234, not 1235.
- Switches: sw=10'h2AA held → FFF2 reads 02AA within 11 cycles; mid-debounce reset → FFF2 reads 0000 until re-debounced.

Source files
------------

// File: rtl/mmio_ctrl_if.sv
// Processor data-memory port as seen by the MMIO controller.
// Ports: addr/wdata/we from the processor, rdata/io_sel back to it.
// master = processor side, slave = mmio_ctrl side.
interface mmio_ctrl_if #(
  parameter int DBITS = 16
);
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic             we;
  logic [DBITS-1:0] rdata;
  logic             io_sel;

  modport master (output addr, output wdata, output we, input rdata, input io_sel);
  modport slave  (input addr, input wdata, input we, output rdata, output io_sel);
endinterface

// File: rtl/mmio_ctrl.sv
// MMIO controller for the 0xFFF0-0xFFFF window: HEX/LEDR/LEDG registers,
// debounced KEY/SW inputs, sticky key-press status, millisecond counter.
// Ports: clk, rst_n (sync, active-low), bus (slave), key_n, sw, hex_out, ledr, ledg.
// Loads are combinational; stores take effect at the clock edge (1-cycle to pins).
module mmio_ctrl #(
  parameter int DBITS       = 16,
  parameter int DEB_CYCLES  = 500000,
  parameter int TICK_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  mmio_ctrl_if.slave  bus,
  input  logic [3:0]  key_n,
  input  logic [9:0]  sw,
  output logic [15:0] hex_out,
  output logic [9:0]  ledr,
  output logic [7:0]  ledg
);
  localparam int DEB_W  = (DEB_CYCLES  > 2) ? $clog2(DEB_CYCLES)  : 1;
  localparam int TICK_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

  logic [3:0]        key_s1, key_s2, key_samp, key_db, key_db_d;
  logic [9:0]        sw_s1, sw_s2, sw_samp, sw_db;
  logic [3:0]        kstat;
  logic [15:0]       mscnt;
  logic [DEB_W-1:0]  deb_cnt;
  logic [TICK_W-1:0] tick_cnt;

  logic        deb_tick, ms_tick, wr_en;
  logic [2:0]  reg_idx;
  logic [3:0]  key_fall, kstat_clr;
  logic [15:0] rd16;
  logic        unused_addr0;

  assign unused_addr0 = bus.addr[0];

  assign bus.io_sel = (bus.addr[15:4] == 12'hFFF);
  assign wr_en      = bus.io_sel & bus.we;
  assign reg_idx    = bus.addr[3:1];

  assign deb_tick = (deb_cnt  == DEB_W'(DEB_CYCLES - 1));
  assign ms_tick  = (tick_cnt == TICK_W'(TICK_CYCLES - 1));

  // key_db_d lags key_db by one cycle, so the fall is seen in the cycle
  // key_db first reads 0 and kstat shows it on the following cycle.
  assign key_fall  = key_db_d & ~key_db;
  assign kstat_clr = (wr_en && reg_idx == 3'd2) ? bus.wdata[3:0] : 4'h0;

  always_comb begin
    rd16 = 16'h0000;
    case (reg_idx)
      3'd0:    rd16 = {12'h000, key_db};
      3'd1:    rd16 = {6'h00, sw_db};
      3'd2:    rd16 = {12'h000, kstat};
      3'd3:    rd16 = mscnt;
      3'd4:    rd16 = hex_out;
      3'd5:    rd16 = {6'h00, ledr};
      3'd6:    rd16 = {8'h00, ledg};
      default: rd16 = 16'h0000;
    endcase
    if (!bus.io_sel) rd16 = 16'hDEAD;
  end

  assign bus.rdata = DBITS'(rd16);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_s1   <= 4'hF;
      key_s2   <= 4'hF;
      key_samp <= 4'hF;
      key_db   <= 4'hF;
      key_db_d <= 4'hF;
      sw_s1    <= '0;
      sw_s2    <= '0;
      sw_samp  <= '0;
      sw_db    <= '0;
      kstat    <= '0;
      mscnt    <= '0;
      deb_cnt  <= '0;
      tick_cnt <= '0;
      hex_out  <= '0;
      ledr     <= '0;
      ledg     <= '0;
    end else begin
      key_s1   <= key_n;
      key_s2   <= key_s1;
      sw_s1    <= sw;
      sw_s2    <= sw_s1;
      key_db_d <= key_db;

      deb_cnt <= deb_tick ? '0 : deb_cnt + 1'b1;
      if (deb_tick) begin
        key_samp <= key_s2;
        sw_samp  <= sw_s2;
        // Per bit: adopt the synchronized value only if it matched the
        // previous sample, otherwise keep the old stable value.
        key_db <= (~(key_samp ^ key_s2) & key_s2) | ((key_samp ^ key_s2) & key_db);
        sw_db  <= (~(sw_samp ^ sw_s2) & sw_s2) | ((sw_samp ^ sw_s2) & sw_db);
      end

      // A new press wins over a simultaneous clear of the same bit.
      kstat <= (kstat & ~kstat_clr) | key_fall;

      tick_cnt <= ms_tick ? '0 : tick_cnt + 1'b1;
      if (wr_en && reg_idx == 3'd3) mscnt <= bus.wdata[15:0];
      else if (ms_tick)             mscnt <= mscnt + 16'd1;

      if (wr_en) begin
        case (reg_idx)
          3'd4:    hex_out <= bus.wdata[15:0];
          3'd5:    ledr    <= bus.wdata[9:0];
          3'd6:    ledg    <= bus.wdata[7:0];
          default: ;
        endcase
      end
    end
  end
endmodule
